// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor sequencer.
package serial_sub_ctrl_pkg;

  localparam int SSC_DEF_WIDTH = 8;
  localparam int SSC_DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ssc_state_e;

endpackage

// File: rtl/serial_sub_ctrl_fs_bit.sv
// One-bit full subtractor built only from two-input NAND gates.
module serial_sub_ctrl_fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic n1, n2, n3, t, m1, m2, m3;

  // t = x ^ y; n3 = ~(y & ~x) gives the generate term for the borrow
  assign n1 = ~(x & y);
  assign n2 = ~(x & n1);
  assign n3 = ~(y & n1);
  assign t  = ~(n2 & n3);

  // m3 = ~(bin & ~t) gives the propagate term for the borrow
  assign m1 = ~(t & bin);
  assign m2 = ~(t & m1);
  assign m3 = ~(bin & m1);
  assign d  = ~(m2 & m3);

  assign bo = ~(n3 & m3);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one shared full-subtractor cell, LSB first,
// with start/busy/done handshake and borrow/less-than/equal flags.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; results hold
//   ST_RUN  | one bit per cycle through the shared cell, WIDTH cycles
//   ST_DONE | single cycle, done=1, results already registered
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = SSC_DEF_WIDTH,
  parameter int CNT_W = SSC_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             lt,
  output logic             eq
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ssc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic             cell_d, cell_bo;
  logic [WIDTH-1:0] r_shift;

  serial_sub_ctrl_fs_bit u_cell (
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    lt_d     = lt_q;
    eq_d     = eq_q;

    // Result register with this cycle's bit already inserted at the MSB, so
    // the last RUN cycle can publish the complete difference directly.
    r_shift            = r_sh_q >> 1;
    r_shift[WIDTH-1]   = cell_d;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          r_sh_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        r_sh_d   = r_shift;
        borrow_d = cell_bo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          diff_d  = r_shift;
          bout_d  = cell_bo;
          lt_d    = cell_bo;
          eq_d    = (r_shift == '0) && !cell_bo;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench: per-cycle comparison against an operation-level model,
// plus literal checks for the directed cases.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, bout, lt, eq;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .lt    (lt),
    .eq    (eq)
  );

  always #5 clk = ~clk;

  // Operation-level model: an accepted operation finishes W edges after the
  // accepting edge and the block is free again one edge later.
  bit           m_init   = 0;
  bit           m_active = 0;
  longint       edge_n   = 0;
  longint       m_start  = 0;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] m_diff   = '0;
  bit           m_bout   = 0;
  bit           m_eq     = 0;
  int           m_starts = 0;
  int           dut_dones = 0;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_init   = 1;
      m_active = 0;
      m_diff   = '0;
      m_bout   = 0;
      m_eq     = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_start  = edge_n;
        m_a      = a;
        m_b      = b;
        m_starts++;
      end
    end else if (edge_n == m_start + W) begin
      m_diff = m_a - m_b;
      m_bout = (m_a < m_b);
      m_eq   = (m_a == m_b);
    end else if (edge_n == m_start + W + 1) begin
      m_active = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_busy", 32'(busy), 32'(m_active));
      chk("model_done", 32'(done), 32'(m_active && (edge_n == m_start + W)));
      chk("model_diff", 32'(diff), 32'(m_diff));
      chk("model_bout", 32'(bout), 32'(m_bout));
      chk("model_lt",   32'(lt),   32'(m_bout));
      chk("model_eq",   32'(eq),   32'(m_eq));
      if (done) dut_dones++;
    end
  end

  // Start one operation from IDLE, wait for done, check literal results and latency.
  task automatic run_op(input string nm, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [W-1:0] ed, input bit eb, input bit ee);
    int k;
    int busy_cycles;
    start = 1'b1;
    a = ai;
    b = bi;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    k = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (busy) busy_cycles++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd9);
    chk({nm, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_bout"}, 32'(bout), 32'(eb));
    chk({nm, "_lt"}, 32'(lt), 32'(eb));
    chk({nm, "_eq"}, 32'(eq), 32'(ee));
    @(negedge clk);
  endtask

  initial begin
    int d0, s0, guard;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1_200_55", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
    run_op("t2_5_10",   8'd5,   8'd10, 8'd251, 1'b1, 1'b0);
    run_op("t3_3c_3c",  8'h3C,  8'h3C, 8'd0,   1'b0, 1'b1);
    run_op("t3_0_0",    8'd0,   8'd0,  8'd0,   1'b0, 1'b1);
    run_op("t3_0_1",    8'd0,   8'd1,  8'd255, 1'b1, 1'b0);
    run_op("t3_ff_0",   8'hFF,  8'd0,  8'hFF,  1'b0, 1'b0);

    // Start ignored while running
    d0 = dut_dones;
    start = 1'b1; a = 8'd100; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'd1; b = 8'd100;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("t4_diff", 32'(diff), 32'd99);
    chk("t4_bout", 32'(bout), 32'd0);
    repeat (20) @(negedge clk);
    chk("t4_done_count", 32'(dut_dones - d0), 32'd1);

    // Reset in the middle of RUN discards the operation
    d0 = dut_dones;
    start = 1'b1; a = 8'd200; b = 8'd55;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_diff", 32'(diff), 32'd0);
    chk("t5_flags", 32'({bout, lt, eq}), 32'd0);
    repeat (12) @(negedge clk);
    chk("t5_no_done", 32'(dut_dones - d0), 32'd0);
    run_op("t5_9_4", 8'd9, 8'd4, 8'd5, 1'b0, 1'b0);

    // Back-to-back random operations, operands changing every cycle
    d0 = dut_dones;
    s0 = m_starts;
    start = 1'b1;
    guard = 0;
    while ((m_starts - s0) < 50 && guard < 2000) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_drained", 32'(busy), 32'd0);
    chk("t6_accepted", 32'(m_starts - s0), 32'd50);
    chk("t6_done_count", 32'(dut_dones - d0), 32'(m_starts - s0));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
